somador_serial_ctrl: RTL

Bit-serial addition controller that sequences one `somador` full-adder cell to add two LARGURA-bit operands, one bit per clock, LSB first. Accepts a start request and latches the operands. Runs LARGURA add cycles while holding the running carry in a register, then pulses a completion flag and holds the result. It sits between a requester (FSM, test harness or datapath) and the single shared full-adder cell, trading latency for area.

---
 rtl/somador_pkg.sv | 15 +
 rtl/somador_serial_ctrl_if.sv | 37 +++
 rtl/somador.sv | 18 +
 rtl/somador_serial_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared types and constants for the bit-serial adder
// Contents:
//   estado_t        controller state encoding (OCIOSO, SOMANDO, FIM)
//   LARGURA_PADRAO  default operand/result width
package somador_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SOMANDO = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam int LARGURA_PADRAO = 8;

endpackage

// File: rtl/somador_serial_ctrl_if.sv
// rtl/somador_serial_ctrl_if.sv - requester/controller bundle for the bit-serial adder
// Optional feature macro: SOMADOR_SERIAL_SUB_EN (adds sub)
// Signals:
//   inicio     requester -> ctrl  start request
//   a, b       requester -> ctrl  operands (LARGURA bits)
//   sub        requester -> ctrl  subtract select (only with SOMADOR_SERIAL_SUB_EN)
//   ocupado    ctrl -> requester  operation in progress
//   pronto     ctrl -> requester  one-cycle result-valid pulse
//   soma       ctrl -> requester  result (LARGURA bits)
//   carry_out  ctrl -> requester  carry out of the MSB
// Modports: master (requester side), slave (controller side)
interface somador_serial_ctrl_if
  import somador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);

  logic               inicio;
  logic [LARGURA-1:0] a;
  logic [LARGURA-1:0] b;
`ifdef SOMADOR_SERIAL_SUB_EN
  logic               sub;
`endif
  logic               ocupado;
  logic               pronto;
  logic [LARGURA-1:0] soma;
  logic               carry_out;

`ifdef SOMADOR_SERIAL_SUB_EN
  modport master (output inicio, a, b, sub, input ocupado, pronto, soma, carry_out);
  modport slave  (input inicio, a, b, sub, output ocupado, pronto, soma, carry_out);
`else
  modport master (output inicio, a, b, input ocupado, pronto, soma, carry_out);
  modport slave  (input inicio, a, b, output ocupado, pronto, soma, carry_out);
`endif

endinterface

// File: rtl/somador.sv
// rtl/somador.sv - single-bit full-adder cell
// Ports:
//   a, b    in   operand bits
//   c       in   carry-in
//   saida1  out  sum bit
//   saida2  out  carry-out
module somador (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic saida1,
  output logic saida2
);

  assign saida1 = a ^ b ^ c;
  assign saida2 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/somador_serial_ctrl.sv
// rtl/somador_serial_ctrl.sv - bit-serial adder controller around one shared full-adder cell
// Optional feature macro: SOMADOR_SERIAL_SUB_EN (subtract mode via bus.sub)
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    somador_serial_ctrl_if.slave (inicio, a, b, [sub], ocupado, pronto, soma, carry_out)
module somador_serial_ctrl
  import somador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                 clk,
  input  logic                 reset,
  somador_serial_ctrl_if.slave bus
);

  localparam int CW = $clog2(LARGURA);

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d;
  logic [LARGURA-1:0] soma_q, soma_d;
  logic               carry_q, carry_d;
  logic               bit_soma;
  logic               bit_carry;

  somador u_somador (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .c      (carry_q),
    .saida1 (bit_soma),
    .saida2 (bit_carry)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    soma_d   = soma_q;
    carry_d  = carry_q;
    case (estado_q)
      OCIOSO: begin
        if (bus.inicio) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = 1'b0;
`ifdef SOMADOR_SERIAL_SUB_EN
          // Two's complement: A + ~B + 1
          if (bus.sub) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          cnt_d    = '0;
          estado_d = SOMANDO;
        end
      end
      SOMANDO: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Result fills from the MSB so bit 0 lands at soma[0] after LARGURA shifts
        soma_d  = {bit_soma, soma_q[LARGURA-1:1]};
        carry_d = bit_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(LARGURA - 1)) begin
          estado_d = FIM;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      soma_q   <= '0;
      carry_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      soma_q   <= soma_d;
      carry_q  <= carry_d;
    end
  end

  // After the last SOMANDO edge the carry register holds the MSB carry-out
  assign bus.ocupado   = (estado_q != OCIOSO);
  assign bus.pronto    = (estado_q == FIM);
  assign bus.soma      = soma_q;
  assign bus.carry_out = carry_q;

endmodule
